// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus between the PC sequencer (master) and imem (slave).
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch sequencer: IDLE -> FETCH -> (WAIT) -> EXEC loop with watchdog,
// halt and retire count. Optional misaligned-target trap under `PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        rstn,
  pc_fetch_sequencer_if.master        imem,
  input  logic                        start,
  output logic [31:0]                 instr,
  output logic                        instr_valid,
  input  logic                        exec_done,
  input  logic [2:0]                  branch,
  input  logic                        zero,
  input  logic                        less,
  input  logic [31:0]                 busA,
  input  logic [31:0]                 imm,
  input  logic                        halt,
  output logic [31:0]                 pc,
  output logic                        halted,
  output logic                        err,
  output logic                        misalign,
  output logic [31:0]                 instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT, S_ERR
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic [15:0] wdog_q, wdog_d;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  logic        taken, use_busa;
  logic [31:0] op_a, op_b, next_pc;

  // Target adder: bit 0 of both register and immediate operands is cleared.
  always_comb begin
    taken    = 1'b0;
    use_busa = 1'b0;
    case (branch)
      3'b001:  taken = 1'b1;
      3'b010:  begin taken = 1'b1; use_busa = 1'b1; end
      3'b100:  taken = zero;
      3'b101:  taken = ~zero;
      3'b110:  taken = less;
      3'b111:  taken = ~less;
      default: taken = 1'b0;
    endcase
    op_a    = use_busa ? (busA & ~32'd1) : pc_q;
    op_b    = taken ? (imm & ~32'd1) : 32'd4;
    next_pc = op_a + op_b;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    wdog_d    = wdog_q;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem.imem_gnt) begin
          wdog_d = '0;
          if (imem.imem_rvalid) begin
            instr_d = imem.imem_rdata;
            state_d = S_EXEC;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      // A response arriving on the last allowed cycle still beats the timeout.
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          wdog_d  = '0;
          state_d = S_EXEC;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          instret_d = instret_q + 32'd1;
`ifdef PC_MISALIGN_TRAP_EN
          if (next_pc[1]) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = halt ? S_HALT : S_FETCH;
          end
`else
          pc_d    = next_pc;
          state_d = halt ? S_HALT : S_FETCH;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      wdog_q    <= wdog_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == S_EXEC);
  assign pc             = pc_q;
  assign halted         = (state_q == S_HALT);
  assign err            = (state_q == S_ERR);
  assign instret        = instret_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: driver pushes expectations, monitor checks.
module tb_pc_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rstn;
  logic        start, exec_done, zero, less, halt;
  logic [2:0]  branch;
  logic [31:0] busA, imm;
  logic [31:0] instr, pc, instret;
  logic        instr_valid, halted, err, misalign;

  always #5 clk = ~clk;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .imem(bus), .start(start),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .branch(branch), .zero(zero), .less(less), .busA(busA), .imm(imm),
    .halt(halt), .pc(pc), .halted(halted), .err(err), .misalign(misalign),
    .instret(instret)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instret;
    logic        halted;
    logic        misalign;
  } st_t;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  st_t         exp_st_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] pc_m, instret_m;
  logic        halted_m, mis_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no expectation/event available @%0t", name, $time);
  endtask

  // Reference next-PC straight from the branch table.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [2:0] br,
                                            input logic z, input logic l,
                                            input logic [31:0] a, input logic [31:0] i);
    bit take;
    logic [31:0] base, off;
    case (br)
      3'd1, 3'd2: take = 1;
      3'd4:       take = z;
      3'd5:       take = !z;
      3'd6:       take = l;
      3'd7:       take = !l;
      default:    take = 0;
    endcase
    base = (br == 3'd2) ? (a & 32'hFFFF_FFFE) : cur;
    off  = take ? (i & 32'hFFFF_FFFE) : 32'd4;
    return base + off;
  endfunction

  // Monitor
  initial begin
    logic [31:0] cur_instr;
    bit pend, prev_iv;
    st_t e;
    cur_instr = '0; pend = 0; prev_iv = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend = 0; prev_iv = 0;
      end else begin
        if (pend) begin
          pend = 0;
          if (exp_st_q.size() == 0) miss("retire_state");
          else begin
            e = exp_st_q.pop_front();
            chk("retire_pc", pc, e.pc);
            chk("retire_instret", instret, e.instret);
            chk("retire_halted", {31'd0, halted}, {31'd0, e.halted});
            chk("retire_misalign", {31'd0, misalign}, {31'd0, e.misalign});
          end
        end
        if (bus.imem_req && bus.imem_gnt) begin
          if (exp_addr_q.size() == 0) miss("fetch_addr");
          else chk("fetch_addr", bus.imem_addr, exp_addr_q.pop_front());
        end
        if (instr_valid && !prev_iv) begin
          if (exp_instr_q.size() == 0) miss("instr");
          else cur_instr = exp_instr_q.pop_front();
        end
        if (instr_valid) chk("instr_hold", instr, cur_instr);
        if (instr_valid && exec_done) pend = 1;
        prev_iv = instr_valid;
      end
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic model_reset;
    pc_m = 32'h0; instret_m = 32'h0; halted_m = 0; mis_m = 0;
    exp_addr_q.delete(); exp_instr_q.delete(); exp_st_q.delete();
  endtask

  task automatic do_instr(input logic [31:0] word, input logic [2:0] br, input logic z,
                          input logic l, input logic [31:0] a, input logic [31:0] i,
                          input logic h, input bit same, input int gd, input int wd,
                          input int ed);
    int n;
    logic [31:0] npc;
    n = 0;
    while (!bus.imem_req && n < 20) begin step; n++; end
    if (!bus.imem_req) begin miss("req_wait_timeout"); return; end
    exp_addr_q.push_back(pc_m);
    repeat (gd) step;
    bus.imem_gnt = 1; bus.imem_rvalid = same;
    bus.imem_rdata = same ? word : $urandom;
    if (same) exp_instr_q.push_back(word);
    step;
    bus.imem_gnt = 0; bus.imem_rvalid = 0;
    if (!same) begin
      repeat (wd) begin bus.imem_rdata = $urandom; step; end
      bus.imem_rvalid = 1; bus.imem_rdata = word;
      exp_instr_q.push_back(word);
      step;
      bus.imem_rvalid = 0;
    end
    // stray responses during execute must not disturb the held word
    repeat (ed) begin
      bus.imem_rvalid = 1'($urandom); bus.imem_rdata = $urandom; start = 1'($urandom);
      step;
    end
    bus.imem_rvalid = 0; start = 0;
    exec_done = 1; branch = br; zero = z; less = l; busA = a; imm = i; halt = h;
    npc = ref_next(pc_m, br, z, l, a, i);
    instret_m = instret_m + 1;
`ifdef PC_MISALIGN_TRAP_EN
    if (npc[1]) begin mis_m = 1; halted_m = 1; end
    else begin pc_m = npc; halted_m = h; end
`else
    pc_m = npc; halted_m = h;
`endif
    exp_st_q.push_back('{pc: pc_m, instret: instret_m, halted: halted_m, misalign: mis_m});
    step;
    exec_done = 0; halt = 0; branch = $urandom; busA = $urandom; imm = $urandom;
  endtask

  task automatic do_reset_start;
    rstn = 0; step;
    model_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_flags", {27'd0, bus.imem_req, instr_valid, halted, err, misalign}, 32'h0);
    rstn = 1; step;
    start = 1; step; start = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "tb timeout");
  end

  initial begin
    logic [31:0] ra, ri;
    rstn = 0; start = 1; exec_done = 0; branch = 0; zero = 0; less = 0;
    busA = 0; imm = 0; halt = 0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    model_reset();
    step; step;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'h0);
    chk("rst_flags", {28'd0, instr_valid, halted, err, misalign}, 32'h0);
    start = 0; rstn = 1;
    exec_done = 1; bus.imem_rvalid = 1; bus.imem_rdata = 32'hBAD0_BAD0;
    step; step;
    chk("idle_req", {31'd0, bus.imem_req}, 32'h0);
    chk("idle_pc", pc, 32'h0);
    chk("idle_instr", instr, 32'h0);
    exec_done = 0; bus.imem_rvalid = 0;
    start = 1; step; start = 0;

    do_instr(32'h13, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0);               // pc -> 4
    do_instr($urandom, 3'b001, 0, 0, 0, 32'hFC, 0, 0, 1, 0, 1);       // jal -> 0x100
    do_instr($urandom, 3'b010, 0, 0, 32'h2001, 32'h11, 0, 0, 0, 1, 0); // jalr -> 0x2010
    do_instr($urandom, 3'b010, 0, 0, 32'h40, 32'h0, 0, 1, 2, 0, 2);   // -> 0x40
    do_instr($urandom, 3'b100, 1, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 3, 0); // beq taken -> 0x30
    do_instr($urandom, 3'b001, 0, 0, 0, 32'h10, 0, 1, 0, 0, 0);       // -> 0x40
    do_instr($urandom, 3'b100, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 2, 1); // beq not taken -> 0x44
    do_instr($urandom, 3'b010, 0, 0, 32'hFFFF_FFFC, 0, 0, 1, 0, 0, 0); // -> 0xFFFFFFFC
    do_instr($urandom, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0);            // wrap -> 0
    chk("wrap_pc", pc_m, 32'h0);

    for (int k = 0; k < 40; k++) begin
      ra = $urandom; ri = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
      ra = ra & 32'hFFFF_FFFD; ri = ri & 32'hFFFF_FFFD;
`endif
      do_instr($urandom, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), ra, ri, 0,
               bit'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3),
               $urandom_range(0, 2));
    end

    do_instr($urandom, 3'b000, 0, 0, 0, 0, 1, 0, 1, 2, 1);            // halt
    start = 1;
    for (int k = 0; k < 5; k++) begin
      step;
      chk("halt_no_req", {31'd0, bus.imem_req}, 32'h0);
      chk("halted", {31'd0, halted}, 32'h1);
    end
    start = 0;
    chk("halt_err", {31'd0, err}, 32'h0);

`ifdef PC_MISALIGN_TRAP_EN
    do_reset_start();
    do_instr(32'h6F, 3'b001, 0, 0, 0, 32'h6, 0, 1, 0, 0, 0);
    step;
    chk("mis_flag", {31'd0, misalign}, 32'h1);
    chk("mis_pc", pc, 32'h0);
    chk("mis_halted", {31'd0, halted}, 32'h1);
    chk("mis_no_req", {31'd0, bus.imem_req}, 32'h0);
`endif

    // Fetch timeout: grant without data, TIMEOUT=4 WAIT cycles.
    do_reset_start();
    exp_addr_q.push_back(pc_m);
    bus.imem_gnt = 1; step; bus.imem_gnt = 0;
    for (int k = 1; k <= 4; k++) begin
      step;
      chk("tmo_req", {31'd0, bus.imem_req}, 32'h0);
      chk("tmo_err", {31'd0, err}, (k == 4) ? 32'h1 : 32'h0);
    end
    bus.imem_rvalid = 1; bus.imem_rdata = 32'hDEAD_BEEF; step;
    bus.imem_rvalid = 0; step;
    chk("late_err", {31'd0, err}, 32'h1);
    chk("late_instr", instr, 32'h0);
    chk("late_flags", {29'd0, bus.imem_req, instr_valid, halted}, 32'h0);

    step; step;
    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("instr_q_empty", exp_instr_q.size(), 0);
    chk("state_q_empty", exp_st_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
